// File: rtl/line_stream_out.sv
// line_stream_out: pops pixels from an upstream line FIFO and streams one
// frame as a valid/ready beat sequence with sof/eol/eof markers.
// A 2-entry output buffer and a credit check keep the stream at full rate
// without ever overflowing the buffer.
module line_stream_out #(
   parameter int DATA_WIDTH  = 8,
   parameter int LINE_LEN    = 640,
   parameter int FRAME_LINES = 480
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  fifo_empty_i,
   output logic                  fifo_rd_en_o,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  m_sof_o,
   output logic                  m_eol_o,
   output logic                  m_eof_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int TOTAL  = LINE_LEN * FRAME_LINES;
   localparam int PCNT_W = $clog2(TOTAL + 1);
   localparam int COL_W  = $clog2(LINE_LEN);
   localparam int LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

   localparam logic [PCNT_W-1:0] LAST_POP  = PCNT_W'(TOTAL - 1);
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LINE_LEN - 1);
   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(FRAME_LINES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  rd_en;
   logic [1:0]            occ;
   logic [1:0]            occ_nxt;
   logic                  inflight;
   logic                  valid;
   logic                  pop;
   logic [2:0]            credit;
   logic                  wr_idx;
   logic                  last_beat;
   logic                  done_q;
   logic [PCNT_W-1:0]     pop_cnt;
   logic [COL_W-1:0]      col;
   logic [LINE_W-1:0]     line;
   logic [DATA_WIDTH-1:0] slot [2];

   // Buffer occupancy, accepted beats and the credit sum for the pop decision.
   // pop can only be 1 when occ > 0, so the subtractions never wrap.
   assign valid     = (occ != 2'd0);
   assign pop       = valid & m_ready_i & ~rst;
   assign credit    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign occ_nxt   = occ + {1'b0, inflight} - {1'b0, pop};
   assign last_beat = (col == LAST_COL) && (line == LAST_LINE);
   // An arriving word goes behind the surviving head entry; with occ=2 no
   // word can be in flight, so only slots 0 and 1 are ever addressed.
   assign wr_idx    = occ[0] & ~pop;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and pop decision.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      state_nxt = state;
      rd_en     = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) state_nxt = RUN;
         end
         RUN: begin
            rd_en = ~fifo_empty_i & (credit <= 3'd1);
            if (rd_en && (pop_cnt == LAST_POP)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (pop && last_beat) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Occupancy, in-flight pop tracking and the end-of-frame pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ      <= 2'd0;
         inflight <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         occ      <= occ_nxt;
         inflight <= fifo_rd_en_o;
         done_q   <= pop & last_beat;
      end
   end

   // Pop counter for the frame plus column/line position of the head beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         pop_cnt <= '0;
         col     <= '0;
         line    <= '0;
      end else begin
         if ((state == IDLE) && start_i) pop_cnt <= '0;
         else if (fifo_rd_en_o)          pop_cnt <= pop_cnt + 1'b1;

         if (pop) begin
            if (col == LAST_COL) begin
               col  <= '0;
               line <= (line == LAST_LINE) ? '0 : line + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Output buffer storage: head shifts out on accept, FIFO word lands behind it.
   always_ff @(posedge clk) begin
      // NOTE: data slots carry no reset; occ alone says which entries are live,
      // so stale contents after rst are never presented.
      if (pop)      slot[0]      <= slot[1];
      if (inflight) slot[wr_idx] <= fifo_rd_data_i;
   end

   // Reset forces every control output low in the cycle it is asserted.
   assign fifo_rd_en_o = rd_en & ~rst;
   assign m_valid_o    = valid & ~rst;
   assign m_data_o     = slot[0];
   assign m_sof_o      = m_valid_o & (col == '0) & (line == '0);
   assign m_eol_o      = m_valid_o & (col == LAST_COL);
   assign m_eof_o      = m_valid_o & last_beat;
   assign busy_o       = (state != IDLE) & ~rst;
   assign done_o       = done_q & ~rst;

endmodule

// File: tb/tb_line_stream_out.sv
// Bench for line_stream_out with LINE_LEN=4, FRAME_LINES=2.
// A FIFO responder serves words from a queue; a per-cycle checker predicts
// the outputs from the queue of popped-but-unsent words and the frame rules.
module tb_line_stream_out;

   localparam int DW    = 8;
   localparam int LEN   = 4;
   localparam int LINES = 2;
   localparam int TOTAL = LEN * LINES;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_i = 1'b0;
   logic          fifo_empty_i = 1'b1;
   logic          fifo_rd_en_o;
   logic [DW-1:0] fifo_rd_data_i = '0;
   logic          m_valid_o;
   logic          m_ready_i = 1'b1;
   logic [DW-1:0] m_data_o;
   logic          m_sof_o;
   logic          m_eol_o;
   logic          m_eof_o;
   logic          busy_o;
   logic          done_o;

   line_stream_out #(
      .DATA_WIDTH (DW),
      .LINE_LEN   (LEN),
      .FRAME_LINES(LINES)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .fifo_empty_i  (fifo_empty_i),
      .fifo_rd_en_o  (fifo_rd_en_o),
      .fifo_rd_data_i(fifo_rd_data_i),
      .m_valid_o     (m_valid_o),
      .m_ready_i     (m_ready_i),
      .m_data_o      (m_data_o),
      .m_sof_o       (m_sof_o),
      .m_eol_o       (m_eol_o),
      .m_eof_o       (m_eof_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int data;
      bit sof;
      bit eol;
      bit eof;
      int cyc;
   } beat_t;

   int    total = 0;
   int    bad   = 0;
   int    fifo_mem[$];
   int    exp_q[$];
   beat_t blog[$];
   bit    rd_seen = 1'b0;
   int    cyc = 0;
   int    rd_total = 0;
   int    done_cnt = 0;
   int    done_cyc = -1;
   int    first_rd_cyc = -1;
   int    first_val_cyc = -1;
   bit    m_active = 1'b0;
   int    m_pops = 0;
   int    m_beat = 0;
   bit    last_rd = 1'b0;
   bit    prev_eof_acc = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // FIFO responder: a pop seen in cycle t returns its word in cycle t+1.
   always @(posedge clk) begin
      #1;
      if (rd_seen) begin
         check("pop_nonempty", int'(fifo_mem.size() > 0), 1);
         if (fifo_mem.size() > 0) begin
            fifo_rd_data_i = DW'(fifo_mem[0]);
            exp_q.push_back(fifo_mem[0]);
            fifo_mem.delete(0);
         end
      end
      fifo_empty_i = (fifo_mem.size() == 0);
   end

   // Per-cycle checker and behavioural model, sampled mid-cycle.
   always @(negedge clk) begin : chk
      int acc;
      int pending;
      bit was_active;
      cyc++;
      if (rst) begin
         check("rst_outputs", int'({fifo_rd_en_o, m_valid_o, m_sof_o, m_eol_o,
                                    m_eof_o, busy_o, done_o}), 0);
         exp_q.delete();
         m_active     = 1'b0;
         m_pops       = 0;
         m_beat       = 0;
         last_rd      = 1'b0;
         prev_eof_acc = 1'b0;
         rd_seen      = 1'b0;
      end else begin
         was_active = m_active;
         acc        = int'(m_valid_o && m_ready_i);
         pending    = exp_q.size();
         check("valid", int'(m_valid_o), int'((pending - int'(last_rd)) > 0));
         if (m_valid_o && (exp_q.size() > 0)) begin
            check("data", int'(m_data_o), exp_q[0]);
            check("sof", int'(m_sof_o), int'(m_beat == 0));
            check("eol", int'(m_eol_o), int'((m_beat % LEN) == LEN - 1));
            check("eof", int'(m_eof_o), int'(m_beat == TOTAL - 1));
         end
         check("rd_en", int'(fifo_rd_en_o),
               int'(m_active && (m_pops < TOTAL) && !fifo_empty_i && ((pending - acc) <= 1)));
         check("busy", int'(busy_o), int'(m_active));
         check("done", int'(done_o), int'(prev_eof_acc));
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_eof_acc = 1'b0;
         if (fifo_rd_en_o) begin
            m_pops++;
            rd_total++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
         end
         if (m_valid_o && (first_val_cyc < 0)) first_val_cyc = cyc;
         last_rd = fifo_rd_en_o;
         rd_seen = fifo_rd_en_o;
         if (acc != 0) begin
            blog.push_back('{int'(m_data_o), m_sof_o, m_eol_o, m_eof_o, cyc});
            if (exp_q.size() > 0) exp_q.delete(0);
            if (m_beat == TOTAL - 1) begin
               m_active     = 1'b0;
               prev_eof_acc = 1'b1;
               m_beat       = 0;
            end else begin
               m_beat++;
            end
         end
         if (start_i && !was_active) begin
            m_active = 1'b1;
            m_pops   = 0;
            m_beat   = 0;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input int base, input int n);
      for (int i = 0; i < n; i++) fifo_mem.push_back(base + i);
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      step(1);
      start_i = 1'b0;
   endtask

   task automatic clear_log();
      blog.delete();
      first_rd_cyc  = -1;
      first_val_cyc = -1;
      done_cyc      = -1;
      done_cnt      = 0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((done_cnt == 0) && (n < budget)) begin
         step(1);
         n++;
      end
      check("done_within_budget", int'(done_cnt > 0), 1);
   endtask

   task automatic wait_beats(input int k, input int budget);
      int n = 0;
      while ((blog.size() < k) && (n < budget)) begin
         @(negedge clk);
         #2;
         n++;
      end
      check("beats_within_budget", int'(blog.size() >= k), 1);
   endtask

   // Literal frame expectations: words base..base+7, sof at 0, eol at 3 and 7, eof at 7.
   task automatic check_frame(input int base);
      bit [7:0] eol_pat;
      eol_pat = 8'b1000_1000;
      check("beat_count", blog.size(), 8);
      for (int i = 0; i < blog.size() && i < 8; i++) begin
         check("frame_data", blog[i].data, base + i);
         check("frame_sof", int'(blog[i].sof), int'(i == 0));
         check("frame_eol", int'(blog[i].eol), int'(eol_pat[i]));
         check("frame_eof", int'(blog[i].eof), int'(i == 7));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r0;
      int n;

      // Reset state
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
      check("reset_idle", int'({busy_o, m_valid_o, fifo_rd_en_o, done_o}), 0);

      // Full-rate frame
      clear_log();
      load(0, 8);
      pulse_start();
      wait_done(60);
      check_frame(0);
      check("first_valid_latency", first_val_cyc - first_rd_cyc, 2);
      if (blog.size() == 8) begin
         check("back_to_back", blog[7].cyc - blog[0].cyc, 7);
         check("done_latency", done_cyc - blog[7].cyc, 1);
      end
      check("busy_after_done", int'(busy_o), 0);
      step(2);
      check("one_done_full_rate", done_cnt, 1);

      // Backpressure for 5 cycles mid-frame
      clear_log();
      load(10, 8);
      pulse_start();
      wait_beats(3, 40);
      step(1);
      m_ready_i = 1'b0;
      r0 = rd_total;
      step(5);
      check("rd_during_stall", rd_total - r0, 0);
      check("beats_held", blog.size(), 3);
      check("head_held", int'(m_data_o), 13);
      m_ready_i = 1'b1;
      wait_done(60);
      check_frame(10);

      // Starved FIFO after pixel 2
      clear_log();
      load(20, 3);
      pulse_start();
      n = 0;
      while ((fifo_mem.size() > 0) && (n < 20)) begin
         step(1);
         n++;
      end
      check("fifo_drained", fifo_mem.size(), 0);
      r0 = rd_total;
      step(3);
      check("rd_while_empty", rd_total - r0, 0);
      load(23, 5);
      wait_done(60);
      check_frame(20);
      if (blog.size() > 3) check("resume_pixel", blog[3].data, 23);

      // FIFO holding exactly one entry
      clear_log();
      r0 = rd_total;
      load(30, 1);
      pulse_start();
      step(10);
      check("single_pop", rd_total - r0, 1);
      check("single_beat", blog.size(), 1);
      if (blog.size() > 0) check("single_beat_data", blog[0].data, 30);
      load(31, 7);
      wait_done(60);
      check_frame(30);

      // Reset mid-frame after beat 5, last pop still in flight
      clear_log();
      r0 = rd_total;
      load(40, 8);
      pulse_start();
      wait_beats(6, 40);
      check("pops_before_rst", rd_total - r0, 8);
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      clear_log();
      load(50, 8);
      start_i = 1'b1;
      @(negedge clk);
      check("post_rst_outputs", int'({fifo_rd_en_o, m_valid_o, m_sof_o, m_eol_o,
                                      m_eof_o, busy_o, done_o}), 0);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      wait_done(60);
      check_frame(50);

      // start_i pulsed while the frame is running
      clear_log();
      load(60, 8);
      pulse_start();
      step(3);
      pulse_start();
      step(2);
      pulse_start();
      wait_done(60);
      step(5);
      check_frame(60);
      check("single_done", done_cnt, 1);
      check("idle_after_ignored_start", int'(busy_o), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
